// File: rtl/buff_desc_pkg.sv
// Shared layout constants for the buff-description sprite RAM.
// The VGA-side reader and the write-side loader both import this package.
package buff_desc_pkg;

    localparam int BUFF_W    = 92;
    localparam int BUFF_H    = 42;
    localparam int BUFF_SIZE = BUFF_W * BUFF_H;
    localparam int N_BUFF    = 3;

    localparam logic [1:0] BUFF_TYPE_0       = 2'd0;
    localparam logic [1:0] BUFF_TYPE_1       = 2'd1;
    localparam logic [1:0] BUFF_TYPE_2       = 2'd2;
    localparam logic [1:0] BUFF_TYPE_INVALID = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } buff_state_e;

endpackage

// File: rtl/buff_desc_addr_gen.sv
// Raster-order x/y/type counters plus a running RAM address.
// The address is incremented, never computed as base + y*W + x.
module buff_desc_addr_gen import buff_desc_pkg::*; #(
    parameter int IMG_W   = BUFF_W,
    parameter int IMG_H   = BUFF_H,
    parameter int N_TYPES = N_BUFF,
    parameter int ADDR_W  = 14
) (
    input  logic              vga_clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic [1:0]        clear_type,
    input  logic              advance,
    output logic [ADDR_W-1:0] addr,
    output logic              last_pixel,
    output logic              last_type
);

    localparam int X_W = $clog2(IMG_W);
    localparam int Y_W = $clog2(IMG_H);

    logic [X_W-1:0]    x_q, x_d;
    logic [Y_W-1:0]    y_q, y_d;
    logic [1:0]        t_q, t_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] type_base [4];

    // Constant start address of each sprite slot; unused slots map to 0.
    for (genvar gi = 0; gi < 4; gi++) begin : g_base
        assign type_base[gi] = (gi < N_TYPES) ? ADDR_W'(gi * IMG_W * IMG_H) : '0;
    end

    assign last_pixel = (x_q == X_W'(IMG_W - 1)) && (y_q == Y_W'(IMG_H - 1));
    assign last_type  = (t_q == 2'(N_TYPES - 1));
    assign addr       = addr_q;

    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        t_d    = t_q;
        addr_d = addr_q;
        if (clear) begin
            x_d    = '0;
            y_d    = '0;
            t_d    = clear_type;
            addr_d = type_base[clear_type];
        end else if (advance) begin
            addr_d = addr_q + 1'b1;
            if (x_q == X_W'(IMG_W - 1)) begin
                x_d = '0;
                if (y_q == Y_W'(IMG_H - 1)) begin
                    y_d = '0;
                    t_d = t_q + 1'b1;
                end else begin
                    y_d = y_q + 1'b1;
                end
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            x_q    <= '0;
            y_q    <= '0;
            t_q    <= '0;
            addr_q <= '0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            t_q    <= t_d;
            addr_q <= addr_d;
        end
    end

endmodule

// File: rtl/buff_desc_loader.sv
// Streams RGB pixels over valid/ready into the buff-description RAM in raster order,
// optionally continuing through the remaining sprite types without bubbles.
module buff_desc_loader import buff_desc_pkg::*; #(
    parameter int IMG_W   = BUFF_W,
    parameter int IMG_H   = BUFF_H,
    parameter int N_TYPES = N_BUFF,
    parameter int ADDR_W  = 14,
    parameter int DATA_W  = 24
) (
    input  logic              vga_clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [1:0]        buff_type,
    input  logic              load_all,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    buff_state_e       state_q, state_d;
    logic              load_all_q, load_all_d;
    logic              err_q, err_d;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;

    logic              clear, advance, beat, type_ok;
    logic [ADDR_W-1:0] addr;
    logic              last_pixel, last_type;

    buff_desc_addr_gen #(
        .IMG_W   (IMG_W),
        .IMG_H   (IMG_H),
        .N_TYPES (N_TYPES),
        .ADDR_W  (ADDR_W)
    ) u_addr_gen (
        .vga_clk    (vga_clk),
        .reset_n    (reset_n),
        .clear      (clear),
        .clear_type (buff_type),
        .advance    (advance),
        .addr       (addr),
        .last_pixel (last_pixel),
        .last_type  (last_type)
    );

    assign beat    = s_valid && (state_q == LOAD);
    assign type_ok = (buff_type <= 2'(N_TYPES - 1));

    always_comb begin
        state_d    = state_q;
        load_all_d = load_all_q;
        err_d      = 1'b0;
        clear      = 1'b0;
        advance    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (type_ok) begin
                        clear      = 1'b1;
                        load_all_d = load_all;
                        state_d    = LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (beat) begin
                    advance = 1'b1;
                    // At the end of a type, chain into the next one only when asked to.
                    if (last_pixel && !(load_all_q && !last_type)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            load_all_q <= 1'b0;
            err_q      <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            load_all_q <= load_all_d;
            err_q      <= err_d;
            wr_en_q    <= beat;
            if (beat) begin
                wr_addr_q <= addr;
                wr_data_q <= s_data;
            end
        end
    end

    assign s_ready = (state_q == LOAD);
    assign busy    = (state_q == LOAD);
    assign done    = (state_q == DONE);
    assign err     = err_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;

endmodule

// File: tb/tb_buff_desc_loader.sv
// Directed bench for buff_desc_loader: full single-type and chained loads,
// stalled source, rejected start, mid-load reset and ignored extra starts.
module tb_buff_desc_loader;

    logic        vga_clk;
    logic        reset_n;
    logic        start;
    logic [1:0]  buff_type;
    logic        load_all;
    logic        s_valid;
    logic [23:0] s_data;
    logic        s_ready;
    logic        wr_en;
    logic [13:0] wr_addr;
    logic [23:0] wr_data;
    logic        busy;
    logic        done;
    logic        err;

    int total = 0;
    int bad   = 0;

    buff_desc_loader dut (
        .vga_clk   (vga_clk),
        .reset_n   (reset_n),
        .start     (start),
        .buff_type (buff_type),
        .load_all  (load_all),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    // Pixel n of a stream; odd multiplier keeps every value distinct.
    function automatic logic [23:0] pix(input int n);
        logic [31:0] v;
        v = (32'(n) * 32'h0001_0203) ^ 32'h005A_3C96;
        return v[23:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"},   32'(busy),    32'd0);
        check({tag, "_ready"},  32'(s_ready), 32'd0);
        check({tag, "_done"},   32'(done),    32'd0);
        check({tag, "_wr_en"},  32'(wr_en),   32'd0);
        check({tag, "_err"},    32'(err),     32'd0);
    endtask

    // One load from start to done; expected address is base + write index.
    task automatic run_load(input int typ, input bit all, input int n, input int base,
                            input bit rnd, input bit poke);
        int sent, wrote, cyc, dones, limit;
        bit acc;
        sent = 0; wrote = 0; cyc = 0; dones = 0; acc = 0;
        limit = n * 4 + 50;
        start = 1'b1; buff_type = 2'(typ); load_all = all; s_valid = 1'b0;
        @(negedge vga_clk);
        start = 1'b0; buff_type = 2'd0; load_all = 1'b0;
        check("start_busy",  32'(busy),    32'd1);
        check("start_ready", 32'(s_ready), 32'd1);
        while (wrote < n && cyc < limit) begin
            s_valid = (sent < n) && (rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
            s_data  = pix(sent);
            acc     = s_valid && s_ready;
            if (acc) sent++;
            start     = poke && (cyc == 500);
            buff_type = poke ? 2'd2 : 2'd0;
            @(negedge vga_clk);
            cyc++;
            check("wr_en", 32'(wr_en), 32'(acc));
            if (acc) begin
                check("wr_addr", 32'(wr_addr), 32'(base + wrote));
                check("wr_data", 32'(wr_data), 32'(pix(wrote)));
                wrote++;
            end
            check("done", 32'(done), 32'(acc && (wrote == n)));
            if (done) dones++;
            check("err_in_load", 32'(err), 32'd0);
            check("busy",  32'(busy),    32'(wrote < n));
            check("ready", 32'(s_ready), 32'(wrote < n));
        end
        s_valid = 1'b0;
        start   = poke;
        buff_type = poke ? 2'd1 : 2'd0;
        check("writes_total", 32'(wrote), 32'(n));
        check("done_count",   32'(dones), 32'd1);
        @(negedge vga_clk);
        start = 1'b0;
        check_idle("after_done");
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; buff_type = 2'd0; load_all = 1'b0;
        s_valid = 1'b0; s_data = 24'd0;
        repeat (3) @(negedge vga_clk);
        check_idle("reset");
        check("reset_addr", 32'(wr_addr), 32'd0);
        check("reset_data", 32'(wr_data), 32'd0);
        reset_n = 1'b1;
        @(negedge vga_clk);

        run_load(1, 1'b0, 3864, 3864, 1'b0, 1'b0);
        run_load(0, 1'b1, 11592, 0, 1'b0, 1'b1);
        run_load(2, 1'b0, 3864, 7728, 1'b1, 1'b0);

        // Rejected start: type 3 with a valid source waiting.
        start = 1'b1; buff_type = 2'd3; load_all = 1'b0; s_valid = 1'b1; s_data = pix(7);
        @(negedge vga_clk);
        start = 1'b0; buff_type = 2'd0;
        check("rej_err",   32'(err),     32'd1);
        check("rej_busy",  32'(busy),    32'd0);
        check("rej_ready", 32'(s_ready), 32'd0);
        check("rej_wr_en", 32'(wr_en),   32'd0);
        @(negedge vga_clk);
        check("rej_err_clear", 32'(err),   32'd0);
        check("rej_wr_en2",    32'(wr_en), 32'd0);
        s_valid = 1'b0;

        // Reset after 100 accepted beats of a type-0 load.
        start = 1'b1; buff_type = 2'd0; load_all = 1'b1;
        @(negedge vga_clk);
        start = 1'b0; load_all = 1'b0;
        check("rst_test_ready", 32'(s_ready), 32'd1);
        for (int i = 0; i < 100; i++) begin
            s_valid = 1'b1; s_data = pix(i);
            @(negedge vga_clk);
        end
        check("pre_rst_wr_en", 32'(wr_en),   32'd1);
        check("pre_rst_addr",  32'(wr_addr), 32'd99);
        reset_n = 1'b0; s_valid = 1'b0;
        @(negedge vga_clk);
        check_idle("mid_reset");
        check("mid_reset_addr", 32'(wr_addr), 32'd0);
        check("mid_reset_data", 32'(wr_data), 32'd0);
        reset_n = 1'b1;
        @(negedge vga_clk);
        run_load(0, 1'b0, 3864, 0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
